// File: rtl/rotozoom_param_gen.sv
// Per-frame rotozoom parameter generator: button-driven angle/scale update, sequential
// multiply into texture strides, centre offset. Optional build macro: ROTOZOOM_AUTOSPIN_EN.
module rotozoom_param_gen #(
  parameter logic [15:0] SCALE_INIT = 16'h4000,
  parameter int          SCALE_STEP = 50,
  parameter logic [15:0] SCALE_MIN  = 16'h0400,
  parameter logic [15:0] SCALE_MAX  = 16'h7FFF,
  parameter int unsigned TEX_SHIFT  = 3,
  parameter int          CENTRE_X   = 320,
  parameter int          CENTRE_Y   = 240
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               frame_start,
  input  logic               btn_inc_angle,
  input  logic               btn_dec_angle,
  input  logic               btn_inc_zoom,
  input  logic               btn_dec_zoom,
  input  logic signed [15:0] cos_val,
  input  logic signed [15:0] sin_val,
  output logic [7:0]         angle,
  output logic signed [16:0] u_stride,
  output logic signed [16:0] v_stride,
  output logic signed [16:0] u_start,
  output logic signed [16:0] v_start,
  output logic               params_valid,
  output logic               busy,
  output logic               overrun
);

  typedef enum logic [2:0] {
    StIdle, StUpdate, StWaitTab, StMulU, StMulV, StOffset, StDone
  } state_e;

`ifdef ROTOZOOM_AUTOSPIN_EN
  localparam bit AutoSpin = 1'b1;
`else
  localparam bit AutoSpin = 1'b0;
`endif

  localparam logic signed [17:0] ScaleStep = 18'(SCALE_STEP);
  localparam logic signed [17:0] ScaleMin  = $signed({2'b00, SCALE_MIN});
  localparam logic signed [17:0] ScaleMax  = $signed({2'b00, SCALE_MAX});
  localparam logic signed [16:0] CentreX   = 17'(CENTRE_X);
  localparam logic signed [16:0] CentreY   = 17'(CENTRE_Y);

  state_e state_q, state_d;

  // Sync bit order: {inc_angle, dec_angle, inc_zoom, dec_zoom}
  logic [3:0]         sync1_q, sync2_q;
  logic [7:0]         angle_q, angle_upd;
  logic [15:0]        scale_q, scale_upd;
  logic signed [17:0] scale_sum;
  logic signed [15:0] sin_q;
  logic signed [31:0] mcand_q, acc_q, acc_step, partial;
  logic [15:0]        mplier_q;
  logic [3:0]         bit_cnt_q;
  logic signed [16:0] stride_c;
  logic signed [16:0] u_str_q, v_str_q;
  logic signed [16:0] u_start_c, v_start_c;
  logic signed [16:0] u_stride_q, v_stride_q, u_start_q, v_start_q;
  logic               overrun_q;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (frame_start) state_d = StUpdate;
      StUpdate:  state_d = StWaitTab;
      StWaitTab: state_d = StMulU;
      StMulU:    if (bit_cnt_q == 4'd15) state_d = StMulV;
      StMulV:    if (bit_cnt_q == 4'd15) state_d = StOffset;
      StOffset:  state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs; the new angle is presented during UPDATE so the registered tables hold
  // its cos/sin by the end of WAIT_TAB.
  always_comb begin
    angle        = (state_q == StUpdate) ? angle_upd : angle_q;
    busy         = (state_q != StIdle);
    params_valid = (state_q == StDone);
  end

  assign u_stride = u_stride_q;
  assign v_stride = v_stride_q;
  assign u_start  = u_start_q;
  assign v_start  = v_start_q;
  assign overrun  = overrun_q;

  always_comb begin
    angle_upd = angle_q;
    if (sync2_q[3] && !sync2_q[2])                   angle_upd = angle_q + 8'd1;
    else if (!sync2_q[3] && sync2_q[2])              angle_upd = angle_q - 8'd1;
    else if (AutoSpin && !sync2_q[3] && !sync2_q[2]) angle_upd = angle_q + 8'd1;
  end

  always_comb begin
    scale_sum = $signed({2'b00, scale_q});
    if (sync2_q[1] && !sync2_q[0])      scale_sum = scale_sum + ScaleStep;
    else if (!sync2_q[1] && sync2_q[0]) scale_sum = scale_sum - ScaleStep;
    if (scale_sum > ScaleMax)      scale_upd = SCALE_MAX;
    else if (scale_sum < ScaleMin) scale_upd = SCALE_MIN;
    else                           scale_upd = scale_sum[15:0];
  end

  // Shift-add step; bit 15 of the multiplier carries negative weight (two's complement).
  always_comb begin
    partial  = mplier_q[0] ? mcand_q : 32'sd0;
    acc_step = (bit_cnt_q == 4'd15) ? acc_q - partial : acc_q + partial;
    stride_c = 17'(acc_step >>> (16 + TEX_SHIFT));
  end

  always_comb begin
    u_start_c = CentreY * v_str_q - CentreX * u_str_q;
    v_start_c = -(CentreX * v_str_q) - CentreY * u_str_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      angle_q    <= '0;
      scale_q    <= SCALE_INIT;
      sin_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      bit_cnt_q  <= '0;
      u_str_q    <= '0;
      v_str_q    <= '0;
      u_stride_q <= '0;
      v_stride_q <= '0;
      u_start_q  <= '0;
      v_start_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      sync1_q   <= {btn_inc_angle, btn_dec_angle, btn_inc_zoom, btn_dec_zoom};
      sync2_q   <= sync1_q;
      overrun_q <= frame_start && (state_q != StIdle);
      unique case (state_q)
        StUpdate: begin
          angle_q <= angle_upd;
          scale_q <= scale_upd;
        end
        StWaitTab: begin
          sin_q     <= sin_val;
          mcand_q   <= {{16{cos_val[15]}}, cos_val};
          mplier_q  <= scale_q;
          acc_q     <= '0;
          bit_cnt_q <= '0;
        end
        StMulU, StMulV: begin
          acc_q     <= acc_step;
          mcand_q   <= mcand_q <<< 1;
          mplier_q  <= mplier_q >> 1;
          bit_cnt_q <= bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            if (state_q == StMulU) begin
              u_str_q  <= stride_c;
              acc_q    <= '0;
              mcand_q  <= {{16{sin_q[15]}}, sin_q};
              mplier_q <= scale_q;
            end else begin
              v_str_q <= stride_c;
            end
          end
        end
        StOffset: begin
          u_stride_q <= u_str_q;
          v_stride_q <= v_str_q;
          u_start_q  <= u_start_c;
          v_start_q  <= v_start_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rotozoom_param_gen.sv
// Scoreboard bench for rotozoom_param_gen: a reference model pushes expected parameters at
// each accepted frame_start; the monitor pops and compares on params_valid.
module tb_rotozoom_param_gen;

  localparam int StrideShift = 19;
  localparam int CentreX     = 320;
  localparam int CentreY     = 240;

  logic        clk = 1'b0;
  logic        resetn, frame_start;
  logic        bia, bda, biz, bdz;
  logic [15:0] cos_val, sin_val;
  logic [7:0]  angle;
  logic [16:0] u_stride, v_stride, u_start, v_start;
  logic        params_valid, busy, overrun;

  always #5 clk = ~clk;

  rotozoom_param_gen dut (
    .clk          (clk),
    .resetn       (resetn),
    .frame_start  (frame_start),
    .btn_inc_angle(bia),
    .btn_dec_angle(bda),
    .btn_inc_zoom (biz),
    .btn_dec_zoom (bdz),
    .cos_val      (cos_val),
    .sin_val      (sin_val),
    .angle        (angle),
    .u_stride     (u_stride),
    .v_stride     (v_stride),
    .u_start      (u_start),
    .v_start      (v_start),
    .params_valid (params_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  typedef struct {
    logic [16:0] us, vs, ust, vst;
    logic [7:0]  ang;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_checks = 0, n_fail = 0;
  int   cyc = 0, pv_cnt = 0, ovr_cnt = 0, ovr_cyc = -1;
  int   tab_mode = 0;
  logic [7:0] angle_m;
  int   scale_m;

  function automatic logic [15:0] cos_f(input logic [7:0] a);
    if (tab_mode == 0) return 16'h7FFF;
    return 16'(28672 - int'(a) * 211);
  endfunction

  function automatic logic [15:0] sin_f(input logic [7:0] a);
    if (tab_mode == 0) return 16'h0000;
    return 16'(int'(a) * 173 - 20000);
  endfunction

  // Trig tables with one registered cycle of latency
  always @(posedge clk) begin
    cos_val <= cos_f(angle);
    sin_val <= sin_f(angle);
    cyc     <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (overrun) begin
      ovr_cnt++;
      ovr_cyc = cyc;
    end
    if (params_valid) begin
      pv_cnt++;
      if (sb.size() == 0) begin
        check("pv_unexpected", 32'(sb.size()), 32'd1);
      end else begin
        e_mon = sb.pop_front();
        check("u_stride", 32'(u_stride), 32'(e_mon.us));
        check("v_stride", 32'(v_stride), 32'(e_mon.vs));
        check("u_start", 32'(u_start), 32'(e_mon.ust));
        check("v_start", 32'(v_start), 32'(e_mon.vst));
        check("angle", 32'(angle), 32'(e_mon.ang));
        check("pv_cycle", cyc, e_mon.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    {bia, bda, biz, bdz} = 4'b0;
    frame_start = 1'b0;
    sb.delete();
    repeat (2) tick();
    resetn  = 1'b1;
    angle_m = 8'h00;
    scale_m = 32'h4000;
  endtask

  task automatic start_frame(input logic ia, da, iz, dz);
    exp_t e;
    int   c, s, usi, vsi;
    {bia, bda, biz, bdz} = {ia, da, iz, dz};
    repeat (3) tick();
    if (ia && !da)      angle_m = angle_m + 8'd1;
    else if (da && !ia) angle_m = angle_m - 8'd1;
`ifdef ROTOZOOM_AUTOSPIN_EN
    else if (!ia && !da) angle_m = angle_m + 8'd1;
`endif
    if (iz && !dz)      scale_m = scale_m + 50;
    else if (dz && !iz) scale_m = scale_m - 50;
    if (scale_m > 32'h7FFF) scale_m = 32'h7FFF;
    if (scale_m < 32'h0400) scale_m = 32'h0400;
    c     = int'($signed(cos_f(angle_m)));
    s     = int'($signed(sin_f(angle_m)));
    e.us  = 17'((scale_m * c) >>> StrideShift);
    e.vs  = 17'((scale_m * s) >>> StrideShift);
    usi   = int'($signed(e.us));
    vsi   = int'($signed(e.vs));
    e.ust = 17'(CentreY * vsi - CentreX * usi);
    e.vst = 17'(-CentreX * vsi - CentreY * usi);
    e.ang = angle_m;
    e.cyc = cyc + 36;
    sb.push_back(e);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      check("pv_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic run_frame(input logic ia, da, iz, dz);
    start_frame(ia, da, iz, dz);
    wait_done();
  endtask

  initial begin
    int t0, o0, p0;
    do_reset();
    check("rst_u_stride", 32'(u_stride), 32'd0);
    check("rst_v_stride", 32'(v_stride), 32'd0);
    check("rst_u_start", 32'(u_start), 32'd0);
    check("rst_v_start", 32'(v_start), 32'd0);
    check("rst_angle", 32'(angle), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pv", 32'(params_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // Identity-like frame with constant tables
    tab_mode = 0;
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    check("hold_u_stride", 32'(u_stride), 32'h003FF);
    check("idle_busy", 32'(busy), 32'd0);

    // Angle wrap and button arbitration with angle-dependent tables
    tab_mode = 1;
    run_frame(1'b0, 1'b1, 1'b0, 1'b0);
    check("angle_dec_wrap", 32'(angle), 32'hFF);
    run_frame(1'b1, 1'b1, 1'b0, 1'b0);
    check("angle_both", 32'(angle), 32'hFF);
    run_frame(1'b1, 1'b0, 1'b0, 1'b0);
    check("angle_inc_wrap", 32'(angle), 32'h00);
    run_frame(1'b1, 1'b0, 1'b1, 1'b0);
    run_frame(1'b0, 1'b1, 1'b0, 1'b1);
    run_frame(1'b1, 1'b0, 1'b1, 1'b1);
    run_frame(1'b0, 1'b1, 1'b0, 1'b0);

    // Second frame_start while busy
    o0 = ovr_cnt;
    p0 = pv_cnt;
    start_frame(1'b0, 1'b0, 1'b0, 1'b0);
    t0 = cyc - 1;
    repeat (9) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_done();
    repeat (5) tick();
    check("overrun_count", 32'(ovr_cnt - o0), 32'd1);
    check("overrun_cycle", ovr_cyc, t0 + 11);
    check("overrun_pv_count", 32'(pv_cnt - p0), 32'd1);

    // Reset 20 cycles into a computation
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (19) tick();
    resetn = 1'b0;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_u_stride", 32'(u_stride), 32'd0);
    check("abort_v_stride", 32'(v_stride), 32'd0);
    check("abort_u_start", 32'(u_start), 32'd0);
    check("abort_v_start", 32'(v_start), 32'd0);
    check("abort_angle", 32'(angle), 32'd0);
    resetn  = 1'b1;
    angle_m = 8'h00;
    scale_m = 32'h4000;
    p0      = pv_cnt;
    repeat (40) tick();
    check("abort_no_pv", 32'(pv_cnt - p0), 32'd0);

    // Three button-free frames: angle follows the spin setting
    tab_mode = 0;
    for (int i = 0; i < 3; i++) begin
      run_frame(1'b0, 1'b0, 1'b0, 1'b0);
      check("spin_angle", 32'(angle), 32'(angle_m));
    end

    // Zoom in to the upper limit and stay there
    for (int i = 0; i < 400 && scale_m < 32'h7FFF; i++) run_frame(1'b0, 1'b0, 1'b1, 1'b0);
    run_frame(1'b0, 1'b0, 1'b1, 1'b0);
    run_frame(1'b0, 1'b0, 1'b1, 1'b0);
    check("scale_max_stride", 32'(u_stride), 32'h007FF);

    // Zoom out to the lower limit and stay there
    do_reset();
    for (int i = 0; i < 400 && scale_m > 32'h0400; i++) run_frame(1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);
    check("scale_min_stride", 32'(u_stride), 32'h0003F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rotozoom_param_gen.md
ROTOZOOM_PARAM_GEN -- requirements
Module: rotozoom_param_gen

Interface
REQ-001 Parameter SCALE_INIT, default 16'h4000: scale after reset (signed 2.14).
REQ-002 Parameter SCALE_STEP, default 50: scale change per frame per zoom button.
REQ-003 Parameters SCALE_MIN / SCALE_MAX, defaults 16'h0400 / 16'h7FFF: saturation limits.
REQ-004 Parameter TEX_SHIFT, default 3: extra right shift on strides (texel size).
REQ-005 Parameters CENTRE_X / CENTRE_Y, defaults 320 / 240: rotation centre in pixels.
REQ-006 clk  in  1  pixel clock; single clock domain.
REQ-007 resetn  in  1  reset, synchronous, active-low.
REQ-008 frame_start  in  1  one-cycle pulse at vsync falling edge.
REQ-009 btn_inc_angle, btn_dec_angle, btn_inc_zoom, btn_dec_zoom  in  1 each  raw asynchronous buttons, active-high.
REQ-010 cos_val, sin_val  in  16 each  signed trig-table outputs; one-cycle registered latency from angle.
REQ-011 angle  out  8  trig-table index (drives tables); updates in UPDATE.
REQ-012 u_stride, v_stride  out  17 each  signed per-pixel texture steps.
REQ-013 u_start, v_start  out  17 each  signed texture coordinate of pixel (0,0).
REQ-014 params_valid  out  1  one-cycle pulse: stride/start outputs just updated.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 overrun  out  1  one-cycle pulse: frame_start arrived while busy.

Function
REQ-017 Each button passes through a 2-flop synchroniser; synchronised level sampled only in UPDATE.
REQ-018 FSM states: IDLE, UPDATE, WAIT_TAB, MUL_U, MUL_V, OFFSET, DONE.
REQ-019 IDLE -> UPDATE on frame_start; UPDATE -> WAIT_TAB; WAIT_TAB -> MUL_U; MUL_U -> MUL_V after 16 cycles; MUL_V -> OFFSET after 16 cycles; OFFSET -> DONE; DONE -> IDLE.
REQ-020 UPDATE: angle +1 if inc only, -1 if dec only, unchanged if both or neither; wraps mod 256.
REQ-021 UPDATE: scale +SCALE_STEP if inc_zoom only, -SCALE_STEP if dec_zoom only, unchanged if both; result clamped to [SCALE_MIN, SCALE_MAX].
REQ-022 WAIT_TAB: cos_val/sin_val for new angle captured at end of state.
REQ-023 MUL_U/MUL_V: sequential signed 16x16 shift-add multiply, one bit per cycle, 32-bit signed product.
REQ-024 Stride = product >>> (16+TEX_SHIFT), arithmetic, truncated to low 17 bits; u from cos, v from sin.
REQ-025 OFFSET: u_start = -CENTRE_X*u_stride + CENTRE_Y*v_stride; v_start = -CENTRE_X*v_stride - CENTRE_Y*u_stride; 17-bit two's-complement wrap.
REQ-026 Outputs u_stride, v_stride, u_start, v_start are double-buffered: change only in DONE, stable all frame.
REQ-027 params_valid high exactly in DONE; latency frame_start sample to params_valid = 36 cycles.
REQ-028 frame_start while busy: ignored, overrun pulses next cycle, computation continues unaffected.

Reset
REQ-029 resetn low at a clk edge: FSM -> IDLE, angle 0, scale SCALE_INIT, all stride/start outputs 0, params_valid/busy/overrun 0, synchronisers 0.
REQ-030 Reset mid-computation aborts; no params_valid pulse for the aborted frame.

Configuration
REQ-031 Macro ROTOZOOM_AUTOSPIN_EN defined: in UPDATE with neither angle button active, angle advances +1.
REQ-032 Macro ROTOZOOM_AUTOSPIN_EN undefined: angle changes only by buttons.

Verification
REQ-033 Reset, scale 16'h4000, cos_val 16'h7FFF, sin_val 0, one frame_start, no buttons (autospin off) -> u_stride 17'h003FF, v_stride 0, u_start 17'h10140, v_start 17'h040F0, params_valid at cycle 36.
REQ-034 btn_inc_zoom held with scale = SCALE_MAX-10 -> scale saturates at 16'h7FFF, stays there next frame.
REQ-035 Both angle buttons held, angle 8'hFF -> angle stays 8'hFF; inc only -> 8'h00 (wrap).
REQ-036 Second frame_start 10 cycles after first -> overrun pulse once, single params_valid at cycle 36.
REQ-037 resetn low at cycle 20 of computation -> outputs 0, no params_valid, busy 0 next cycle.
REQ-038 ROTOZOOM_AUTOSPIN_EN defined, no buttons, 3 frames -> angle 0,1,2,3 progression; undefined -> stays 0.
